m68k_bus_sequencer: RTL

M68K_BUS_SEQUENCER -- requirements
Module: m68k_bus_sequencer

---
 rtl/m68k_bus_sequencer_if.sv | 60 ++++++
 rtl/m68k_bus_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/m68k_bus_sequencer_if.sv
// Request/response handshakes and 68000 bus pins
// shared by the bus sequencer and its neighbours.
interface m68k_bus_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic [1:0]  req_size;
  logic        req_read;
  logic [2:0]  req_fc;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;

  logic        mc_clk_rising;
  logic        mc_clk_falling;
  logic        dtack_n;
  logic        berr_n;
  logic [15:0] din;

  logic [22:0] a_out;
  logic [15:0] d_out;
  logic [2:0]  fc_out;
  logic        abus_oe;
  logic        dbus_oe;
  logic        fc_oe;
  logic        as_oe;
  logic        uds_oe;
  logic        lds_oe;
  logic        rw_oe;
  logic        busy;

  modport master (
    input  req_valid, req_addr, req_size,
    input  req_read, req_fc, req_wdata,
    input  rsp_ready,
    input  mc_clk_rising, mc_clk_falling,
    input  dtack_n, berr_n, din,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_status,
    output a_out, d_out, fc_out,
    output abus_oe, dbus_oe, fc_oe, as_oe,
    output uds_oe, lds_oe, rw_oe, busy
  );

  modport slave (
    output req_valid, req_addr, req_size,
    output req_read, req_fc, req_wdata,
    output rsp_ready,
    output mc_clk_rising, mc_clk_falling,
    output dtack_n, berr_n, din,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_status,
    input  a_out, d_out, fc_out,
    input  abus_oe, dbus_oe, fc_oe, as_oe,
    input  uds_oe, lds_oe, rw_oe, busy
  );
endinterface

// File: rtl/m68k_bus_sequencer.sv
// Queued 68000 bus cycle sequencer: runs S1..S7 off
// 7M edge strobes, splits longs, reports one response.
module m68k_bus_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic sys_clk,
  input logic nRESET,
  m68k_bus_sequencer_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef struct packed {
    logic [23:0] addr;
    logic [1:0]  size;
    logic        read;
    logic [2:0]  fc;
    logic [31:0] wdata;
  } req_t;

  typedef enum logic [2:0] {
    IDLE, S1, S2, S3, S4, S56, S7
  } state_t;

  req_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  req_t          head, cur;
  logic          half;
  logic [TW-1:0] tmo_cnt;
  logic [1:0]    cyc_st;
  logic [31:0]   acc;
  state_t        state, state_nxt;

  logic        push, pop, bad, full, empty;
  logic        term, lane_u, lane_l;
  logic [1:0]  term_st;
  logic [23:0] bus_addr;
  logic [15:0] bus_data;

  assign full  = count == (AW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign head  = mem[rd_ptr];
  assign push  = bus.req_valid && !full;
  assign pop   = state == IDLE && !bus.rsp_valid && !empty;
  assign bad   = head.size == 2'd3 ||
                 (head.size != 2'd0 && head.addr[0]);

  assign bus.req_ready = !full;
  assign bus.busy      = state != IDLE || !empty;
  assign bus.fc_out    = cur.fc;

  assign bus_addr = cur.addr + (half ? 24'd2 : 24'd0);
  assign lane_u   = cur.size != 2'd0 || !cur.addr[0];
  assign lane_l   = cur.size != 2'd0 || cur.addr[0];

  always_comb begin
    bus_data = cur.wdata[31:16];
    unique case (cur.size)
      2'd0:    bus_data = {2{cur.wdata[7:0]}};
      2'd1:    bus_data = cur.wdata[15:0];
      default: bus_data = half ? cur.wdata[15:0]
                               : cur.wdata[31:16];
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= '{
        addr:  bus.req_addr,
        size:  bus.req_size,
        read:  bus.req_read,
        fc:    bus.req_fc,
        wdata: bus.req_wdata
      };
    end
  end

  always_ff @(posedge sys_clk or negedge nRESET) begin
    if (!nRESET) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    term      = 1'b0;
    term_st   = 2'd0;
    unique case (state)
      IDLE: if (pop && !bad) state_nxt = S1;
      S1:   if (bus.mc_clk_falling) state_nxt = S2;
      S2:   if (bus.mc_clk_rising) state_nxt = S3;
      S3:   if (bus.mc_clk_falling) state_nxt = S4;
      S4: begin
        if (bus.mc_clk_falling) begin
          if (!bus.berr_n) begin
            term    = 1'b1;
            term_st = 2'd1;
          end else if (!bus.dtack_n) begin
            term    = 1'b1;
          end else if (tmo_cnt ==
                       TW'(TIMEOUT_CYCLES - 1)) begin
            term    = 1'b1;
            term_st = 2'd2;
          end
        end
        if (term) state_nxt = S56;
      end
      S56:  if (bus.mc_clk_falling) state_nxt = S7;
      S7: begin
        if (bus.mc_clk_rising) begin
          // second half only for a clean first half
          if (cur.size == 2'd2 && !half &&
              cyc_st == 2'd0)
            state_nxt = S1;
          else
            state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge nRESET) begin
    if (!nRESET) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      cur            <= '0;
      half           <= 1'b0;
      tmo_cnt        <= '0;
      cyc_st         <= 2'd0;
      acc            <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_status <= 2'd0;
      bus.rsp_rdata  <= '0;
      bus.a_out      <= '0;
      bus.d_out      <= '0;
      bus.abus_oe    <= 1'b0;
      bus.dbus_oe    <= 1'b0;
      bus.fc_oe      <= 1'b0;
      bus.as_oe      <= 1'b0;
      bus.uds_oe     <= 1'b0;
      bus.lds_oe     <= 1'b0;
      bus.rw_oe      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (bus.rsp_valid && bus.rsp_ready)
        bus.rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop && bad) begin
            bus.rsp_valid  <= 1'b1;
            bus.rsp_status <= 2'd3;
            bus.rsp_rdata  <= '0;
          end else if (pop) begin
            cur        <= head;
            half       <= 1'b0;
            acc        <= '0;
            cyc_st     <= 2'd0;
            bus.fc_oe  <= 1'b1;
          end else if (empty) begin
            bus.fc_oe  <= 1'b0;
          end
        end
        S1: if (state_nxt == S2) begin
          bus.abus_oe <= 1'b1;
          bus.a_out   <= bus_addr[23:1];
        end
        S2: if (state_nxt == S3) begin
          bus.as_oe <= 1'b1;
          bus.rw_oe <= !cur.read;
          if (cur.read) begin
            bus.uds_oe <= lane_u;
            bus.lds_oe <= lane_l;
          end
        end
        S3: if (state_nxt == S4) begin
          tmo_cnt <= '0;
          if (!cur.read) begin
            bus.dbus_oe <= 1'b1;
            bus.d_out   <= bus_data;
          end
        end
        S4: begin
          if (bus.mc_clk_rising && !cur.read) begin
            bus.uds_oe <= lane_u;
            bus.lds_oe <= lane_l;
          end
          if (term)
            cyc_st <= term_st;
          else if (bus.mc_clk_falling)
            tmo_cnt <= tmo_cnt + TW'(1);
        end
        S56: if (state_nxt == S7) begin
          bus.as_oe  <= 1'b0;
          bus.uds_oe <= 1'b0;
          bus.lds_oe <= 1'b0;
          if (cur.read && cyc_st == 2'd0) begin
            unique case (cur.size)
              2'd0: acc <= {24'h0, cur.addr[0]
                             ? bus.din[7:0]
                             : bus.din[15:8]};
              2'd1: acc <= {16'h0, bus.din};
              default:
                if (half) acc[15:0]  <= bus.din;
                else      acc[31:16] <= bus.din;
            endcase
          end
        end
        S7: if (bus.mc_clk_rising) begin
          bus.abus_oe <= 1'b0;
          bus.dbus_oe <= 1'b0;
          bus.rw_oe   <= 1'b0;
          if (state_nxt == S1) begin
            half <= 1'b1;
          end else begin
            bus.rsp_valid  <= 1'b1;
            bus.rsp_status <= cyc_st;
            bus.rsp_rdata  <= cyc_st == 2'd0
                              ? acc : 32'h0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
